// File: rtl/moisture_pump_ctrl.sv
// Soil-moisture pump controller: synchronizes and debounces transistor sensor
// lines, drives per-channel LEDs, and runs a pump FSM with max-on timeout and cooldown.
module moisture_pump_ctrl #(
    parameter int N_CH         = 4,
    parameter int DEB_CYC      = 500000,
    parameter int PUMP_MAX_CYC = 50000000,
    parameter int COOL_CYC     = 25000000,
    parameter int PUMP_ON_WET  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sensor_col_n,
    input  logic [N_CH-1:0] ch_en,
    input  logic            fault_clr,
    output logic [N_CH-1:0] led,
    output logic            pump_on,
    output logic            pump_fault
);

    localparam int MAX_CYC = (PUMP_MAX_CYC > COOL_CYC) ? PUMP_MAX_CYC : COOL_CYC;
    localparam int TW      = $clog2(MAX_CYC) + 1;
    localparam int DW      = $clog2(DEB_CYC + 1);

    localparam logic [TW-1:0] RUN_LAST  = TW'(PUMP_MAX_CYC - 1);
    localparam logic [TW-1:0] COOL_LAST = TW'(COOL_CYC - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_COOL,
        S_FAULT
    } state_t;

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] r_stable_n;
    logic [DW-1:0]   r_deb_cnt [N_CH];

    state_t          r_state;
    state_t          w_next_state;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_next_timer;

    logic [N_CH-1:0] w_want;
    logic            w_demand;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= sensor_col_n;
            r_sync2 <= r_sync1;
        end
    end

    // The stable value flips only after DEB_CYC consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable_n <= '1;
            for (int i = 0; i < N_CH; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (r_sync2[i] == r_stable_n[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_stable_n[i] <= r_sync2[i];
                    r_deb_cnt[i]  <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign led      = ~r_stable_n;
    assign w_want   = (PUMP_ON_WET != 0) ? led : ~led;
    assign w_demand = |(ch_en & w_want);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_next_timer;
        end
    end

    // One timer is shared: it measures run length in RUN and off time in COOL.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        case (r_state)
            S_IDLE: begin
                w_next_timer = '0;
                if (w_demand) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_demand) begin
                    w_next_state = S_COOL;
                    w_next_timer = '0;
                end else if (r_timer == RUN_LAST) begin
                    w_next_state = S_FAULT;
                    w_next_timer = '0;
                end else begin
                    w_next_timer = r_timer + 1'b1;
                end
            end
            S_COOL: begin
                if (r_timer == COOL_LAST) begin
                    w_next_state = S_IDLE;
                    w_next_timer = '0;
                end else begin
                    w_next_timer = r_timer + 1'b1;
                end
            end
            S_FAULT: begin
                w_next_timer = '0;
                if (fault_clr) begin
                    w_next_state = S_COOL;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_timer = '0;
            end
        endcase
    end

    assign pump_on    = (r_state == S_RUN);
    assign pump_fault = (r_state == S_FAULT);

endmodule
